// File: rtl/inst_boot_loader_pkg.sv
// Shared definitions for the UART instruction boot loader.
// Frame constants and state encodings.
package inst_boot_loader_pkg;

  localparam logic [7:0] boot_magic     = 8'hA5;
  localparam int         boot_max_words = 512;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/inst_boot_loader_uart_rx.sv
// 8N1 UART receiver for the boot pin.
// Emits one-cycle byte_valid or frame_err per character.
module boot_uart_rx
  import inst_boot_loader_pkg::*;
#(
  parameter int BIT_CYC = 86
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int          HALF_CYC  = BIT_CYC / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);

  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rx_s, fall;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

  always_comb begin
    sync_d  = {sync_q[1:0], rx};
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          valid_d = rx_s;
          ferr_d  = ~rx_s;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/inst_boot_loader.sv
// Boot loader: framed UART image into instruction memory,
// core held in reset until the checksum verifies.
module inst_boot_loader
  import inst_boot_loader_pkg::*;
#(
  parameter int         CLK_FREQ    = 10_000_000,
  parameter int         BAUD        = 115_200,
  parameter int         MAX_WORDS   = boot_max_words,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] MAGIC       = boot_magic
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_rx,
  output logic [31:0] load_inst_addr,
  output logic [31:0] load_inst_data,
  output logic        load_inst_w_enable,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam int          BIT_CYC  = CLK_FREQ / BAUD;
  localparam logic [15:0] MAX_W    = 16'(MAX_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  boot_uart_rx #(
    .BIT_CYC(BIT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (boot_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  boot_state_e state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] len_w, idx_inc;
  logic [31:0] word_w;
  logic        active;

  assign len_w   = {byte_data, count_q[7:0]};
  assign word_w  = {byte_data, word_q[31:8]};
  assign idx_inc = idx_q + 16'd1;
  assign active  = (state_q == LEN0) || (state_q == LEN1) ||
                   (state_q == DATA) || (state_q == CSUM);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    bsel_d  = bsel_q;
    word_d  = word_q;
    csum_d  = csum_q;
    tmo_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    // inter-byte watchdog and line errors abort an open frame
    if (active) begin
      tmo_d = tmo_q + 32'd1;
      if (byte_valid) begin
        tmo_d = '0;
      end else if (frame_err || tmo_q == TMO_LAST) begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
    if (byte_valid) begin
      unique case (state_q)
        IDLE, ERR: begin
          if (byte_data == MAGIC) begin
            state_d = LEN0;
            err_d   = 1'b0;
            csum_d  = '0;
            idx_d   = '0;
            bsel_d  = '0;
          end
        end
        LEN0: begin
          count_d = {8'h00, byte_data};
          state_d = LEN1;
        end
        LEN1: begin
          count_d = len_w;
          if (len_w == 16'd0 || len_w > MAX_W) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          word_d = word_w;
          csum_d = csum_q + byte_data;
          bsel_d = bsel_q + 2'd1;
          if (bsel_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = {14'd0, idx_q, 2'b00};
            data_d = word_w;
            idx_d  = idx_inc;
            if (idx_inc == count_q) state_d = CSUM;
          end
        end
        CSUM: begin
          if (byte_data == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      bsel_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bsel_q  <= bsel_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign load_inst_addr     = addr_q;
  assign load_inst_data     = data_q;
  assign load_inst_w_enable = we_q;
  assign core_rst_n         = done_q;
  assign load_done          = done_q;
  assign load_err           = err_q;

endmodule
